// File: rtl/flit_arbiter.sv
// Round-robin packet arbiter: picks one upstream FIFO, locks onto it until the
// tail flit is forwarded, and drives a single registered output flit stage.
module flit_arbiter #(
  parameter int WIDTH = 16,
  parameter int PORTS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS-1:0]       in_valid,
  input  logic [PORTS*WIDTH-1:0] in_data,
  output logic [PORTS-1:0]       pop_req_n,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [PORTS-1:0]       grant,
  output logic [15:0]            pkt_count
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    lock_q, lock_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [15:0]      pkt_count_q, pkt_count_d;

  logic             accept;
  logic             sel_found;
  logic [PW-1:0]    sel_idx;
  logic [PW:0]      cand;
  logic [PW-1:0]    pop_idx;
  logic             pop_en;
  logic [WIDTH-1:0] pop_flit;

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] idx);
    if (idx == PW'(PORTS - 1)) return '0;
    return idx + 1'b1;
  endfunction

  // Rotating priority search starting at ptr_q; the first valid port wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < PORTS; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(PORTS)) cand = cand - (PW+1)'(PORTS);
      if (!sel_found && in_valid[cand[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    accept  = !out_valid_q || out_ready;
    pop_idx = (state_q == S_LOCKED) ? lock_q : sel_idx;
    pop_en  = !rst && accept &&
              ((state_q == S_LOCKED) ? in_valid[lock_q] : sel_found);

    pop_flit  = '0;
    pop_req_n = '1;
    grant     = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (pop_idx == PW'(i)) pop_flit = in_data[i*WIDTH +: WIDTH];
      if (pop_en && pop_idx == PW'(i)) pop_req_n[i] = 1'b0;
      grant[i] = (state_q == S_LOCKED) && (lock_q == PW'(i));
    end

    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pkt_count_d = pkt_count_q;

    // A tail flit ends the packet whether it opened it (single-flit) or not.
    if (pop_en) begin
      out_valid_d = 1'b1;
      out_data_d  = pop_flit;
      if (pop_flit[WIDTH-1]) begin
        state_d     = S_IDLE;
        ptr_d       = next_port(pop_idx);
        pkt_count_d = pkt_count_q + 16'd1;
      end else begin
        state_d = S_LOCKED;
        lock_d  = pop_idx;
      end
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      lock_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_flit_arbiter.sv
// Bench for flit_arbiter: FIFO queues per port, a packet-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_flit_arbiter;
  localparam int W = 16;
  localparam int P = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [P-1:0]   in_valid;
  logic [P*W-1:0] in_data;
  logic [P-1:0]   pop_req_n;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [P-1:0]   grant;
  logic [15:0]    pkt_count;

  always #5 clk = ~clk;

  flit_arbiter #(.WIDTH(W), .PORTS(P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .pop_req_n(pop_req_n), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant(grant), .pkt_count(pkt_count)
  );

  logic [W-1:0] fq [P][$];
  int           pop_log[$];
  logic [W-1:0] deliv_log[$];
  int           checks = 0;
  int           errors = 0;

  // Reference model: owner -1 means no packet in progress.
  int           m_owner;
  int           m_ptr;
  bit           m_ov;
  logic [W-1:0] m_od;
  int           m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic present();
    for (int i = 0; i < P; i++) begin
      in_valid[i]       = fq[i].size() > 0;
      in_data[i*W +: W] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic push(input int p, input logic [W-1:0] f);
    fq[p].push_back(f);
    present();
  endtask

  function automatic logic [63:0] enc_pops();
    logic [63:0] c = '0;
    foreach (pop_log[i]) c = (c << 4) | 64'(pop_log[i] + 1);
    return c;
  endfunction

  function automatic logic [63:0] enc_deliv();
    logic [63:0] c = '0;
    foreach (deliv_log[i]) c = (c << 16) | 64'(deliv_log[i]);
    return c;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_ov    = 1'b0;
    m_od    = '0;
    m_cnt   = 0;
  endtask

  // One clock cycle: compare at negedge, let the FIFOs pop at the posedge.
  task automatic tick();
    int           sel;
    int           pop;
    int           pend;
    bit           acc;
    logic [P-1:0] e_popn;
    logic [P-1:0] e_grant;
    logic [W-1:0] f;
    @(negedge clk);
    if (rst) model_reset();
    acc = !m_ov || out_ready;
    pop = -1;
    if (!rst) begin
      if (m_owner < 0) begin
        sel = -1;
        for (int k = 0; k < P; k++) begin
          int c = (m_ptr + k) % P;
          if (sel < 0 && fq[c].size() > 0) sel = c;
        end
        if (acc) pop = sel;
      end else if (acc && fq[m_owner].size() > 0) begin
        pop = m_owner;
      end
    end
    e_popn = '1;
    if (pop >= 0) e_popn[pop] = 1'b0;
    e_grant = '0;
    if (m_owner >= 0) e_grant[m_owner] = 1'b1;
    chk("pop_req_n", 64'(pop_req_n), 64'(e_popn));
    chk("grant", 64'(grant), 64'(e_grant));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_data", 64'(out_data), 64'(m_od));
    chk("pkt_count", 64'(pkt_count), 64'(m_cnt));
    if (out_valid && out_ready && !rst) deliv_log.push_back(out_data);
    pend = -1;
    for (int i = 0; i < P; i++) if (!pop_req_n[i]) pend = i;
    if (pop >= 0) begin
      f    = fq[pop][0];
      m_ov = 1'b1;
      m_od = f;
      if (f[W-1]) begin
        m_owner = -1;
        m_ptr   = (pop + 1) % P;
        m_cnt   = (m_cnt + 1) % 65536;
      end else begin
        m_owner = pop;
      end
    end else if (acc) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    if (pend >= 0 && fq[pend].size() > 0) begin
      void'(fq[pend].pop_front());
      pop_log.push_back(pend);
    end
    present();
    #1;
  endtask

  task automatic reset_begin();
    rst = 1'b1;
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst grant", 64'(grant), 64'd0);
    chk("rst pkt_count", 64'(pkt_count), 64'd0);
    chk("rst pop_req_n", 64'(pop_req_n), 64'hF);
    for (int i = 0; i < P; i++) fq[i].delete();
    pop_log.delete();
    deliv_log.delete();
    present();
  endtask

  task automatic do_reset();
    reset_begin();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    out_ready = 1'b1;
    model_reset();
    present();
    #2;
    do_reset();

    // Idle link
    repeat (10) tick();
    chk("idle pop_req_n", 64'(pop_req_n), 64'hF);
    chk("idle out_valid", 64'(out_valid), 64'd0);
    chk("idle grant", 64'(grant), 64'd0);
    chk("idle pkt_count", 64'(pkt_count), 64'd0);

    // Three-flit packet on port 2
    push(2, 16'h4001); push(2, 16'h0002); push(2, 16'h8003);
    tick();
    chk("p2 grant", 64'(grant), 64'h4);
    chk("p2 head out", 64'(out_data), 64'h4001);
    repeat (5) tick();
    chk("p2 pops", enc_pops(), 64'h333);
    chk("p2 flits", enc_deliv(), 64'h4001_0002_8003);
    chk("p2 pkt_count", 64'(pkt_count), 64'd1);
    // ptr now 3: port 3 must beat port 0
    pop_log.delete();
    push(0, 16'h8010); push(3, 16'h8033);
    repeat (4) tick();
    chk("ptr3 order", enc_pops(), 64'h41);
    chk("ptr3 pkt_count", 64'(pkt_count), 64'd3);

    // Four single-flit packets
    do_reset();
    push(0, 16'h8000); push(1, 16'h8011); push(2, 16'h8022); push(3, 16'h8033);
    repeat (6) tick();
    chk("rr order", enc_pops(), 64'h1234);
    chk("rr flits", enc_deliv(), 64'h8000_8011_8022_8033);
    chk("rr pkt_count", 64'(pkt_count), 64'd4);

    // Lock holds on port 1 while it runs dry
    do_reset();
    push(1, 16'h4100);
    tick();
    push(0, 16'h8000); push(3, 16'h8300);
    repeat (5) tick();
    chk("lock pops", enc_pops(), 64'h2);
    chk("lock grant", 64'(grant), 64'h2);
    push(1, 16'h0101); push(1, 16'h8102);
    repeat (6) tick();
    chk("lock resume", enc_pops(), 64'h22241);
    chk("lock pkt_count", 64'(pkt_count), 64'd3);

    // Downstream backpressure
    do_reset();
    push(0, 16'h4000); push(0, 16'h0001); push(0, 16'h0002); push(0, 16'h8003);
    tick();
    out_ready = 1'b0;
    repeat (4) tick();
    chk("stall out_data", 64'(out_data), 64'h4000);
    chk("stall out_valid", 64'(out_valid), 64'd1);
    chk("stall pops", enc_pops(), 64'h1);
    out_ready = 1'b1;
    repeat (5) tick();
    chk("stall resume pops", enc_pops(), 64'h1111);
    chk("stall flits", enc_deliv(), 64'h4000_0001_0002_8003);
    chk("stall pkt_count", 64'(pkt_count), 64'd1);

    // Reset while locked to port 3
    do_reset();
    push(1, 16'h8100); push(3, 16'h4300); push(3, 16'h0301);
    repeat (4) tick();
    chk("pre-rst pops", enc_pops(), 64'h244);
    chk("pre-rst grant", 64'(grant), 64'h8);
    chk("pre-rst pkt_count", 64'(pkt_count), 64'd1);
    reset_begin();
    push(0, 16'h8000); push(3, 16'h8333);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("post-rst order", enc_pops(), 64'h14);
    chk("post-rst pkt_count", 64'(pkt_count), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
